// File: rtl/branch_pred_unit_pkg.sv
// Shared types and defaults for the branch predictor: BTB geometry, allocation
// counter value and the table entry layout.
package branch_pred_unit_pkg;

  localparam int unsigned BPU_IDX_W     = 6;
  // Tag field sized for the smallest legal index; narrower tags are zero-extended.
  localparam int unsigned BPU_TAG_MAX   = 30;
  localparam logic [1:0]  BPU_CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic [BPU_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    logic [1:0]             ctr;
  } bpu_entry_t;

endpackage

// File: rtl/branch_pred_unit_sat_ctr.sv
// 2-bit saturating up/down counter next-state function.
module sat_ctr2 (
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup for the
// fetch PC, sequential training from execute, plus mispredict statistics.
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int unsigned IDX_W     = BPU_IDX_W,
  parameter int unsigned TAG_W     = 32 - IDX_W - 2,
  parameter logic [1:0]  CTR_ALLOC = BPU_CTR_ALLOC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  bpu_entry_t tbl_q [ENTRIES];

  logic [IDX_W-1:0]       lk_idx, up_idx;
  logic [BPU_TAG_MAX-1:0] lk_tag, up_tag;
  bpu_entry_t             lk_entry, up_entry, wr_entry;
  logic                   lk_hit, up_hit, wr_en;
  logic [1:0]             ctr_nxt;
  logic                   mis;
  logic                   mispredict_q, mispredict_d;
  logic [31:0]            stat_br_q, stat_br_d;
  logic [31:0]            stat_mis_q, stat_mis_d;
  logic                   unused_upd_lsb;

  assign unused_upd_lsb = ^upd_pc[1:0];

  // Lookup path
  assign lk_idx      = pc[IDX_W+1:2];
  assign lk_tag      = BPU_TAG_MAX'(pc[31:32-TAG_W]);
  assign lk_entry    = tbl_q[lk_idx];
  assign lk_hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign pred_taken  = lk_hit && lk_entry.ctr[1] && !reset;
  assign pred_target = lk_hit ? lk_entry.target : pc + 32'd4;

  // Update path
  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = BPU_TAG_MAX'(upd_pc[31:32-TAG_W]);
  assign up_entry = tbl_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr_i (up_entry.ctr),
    .up_i  (upd_taken),
    .ctr_o (ctr_nxt)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (upd_valid && !reset) begin
      if (up_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_nxt;
        if (upd_taken) wr_entry.target = upd_target;
      end else if (upd_taken) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: CTR_ALLOC};
      end
    end
  end

  // Only valid bits are reset; tag/target/ctr are qualified by valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
    end else if (wr_en) begin
      tbl_q[up_idx] <= wr_entry;
    end
  end

  // Statistics and mispredict pulse
  assign mis = (upd_taken != upd_pred_taken) ||
               (upd_taken && (upd_target != upd_pred_target));

  always_comb begin
    mispredict_d = upd_valid && mis;
    stat_br_d    = stat_br_q + 32'(upd_valid);
    stat_mis_d   = stat_mis_q + 32'(upd_valid && mis);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q <= 1'b0;
      stat_br_q    <= '0;
      stat_mis_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      stat_br_q    <= stat_br_d;
      stat_mis_q   <= stat_mis_d;
    end
  end

  assign mispredict    = mispredict_q;
  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mis_q;

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Branch predictor that supplies the fetch stage's next-PC prediction inputs (pred_taken, pred_target) for the current fetch PC.
- Direct-mapped branch target buffer (BTB); each entry holds valid, tag, target and a 2-bit saturating direction counter.
- Lookup is combinational, in the same cycle as the fetch PC. Training is sequential, from resolved-branch updates sent by the execute stage.
- Also keeps resolved-branch and mispredict statistics counters.

Parameters:
- IDX_W, 6, log2 of BTB entry count (64 entries).
- TAG_W, 32-IDX_W-2, tag width; tag = pc[31:IDX_W+2].
- CTR_ALLOC, 2'b10, counter value written when a new entry is allocated (weakly taken).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- pc  input  32  current fetch PC (word aligned)
- pred_taken  output  1  predicted taken for pc
- pred_target  output  32  predicted target for pc
- upd_valid  input  1  one resolved control-transfer instruction this cycle
- upd_pc  input  32  PC of resolved instruction
- upd_taken  input  1  actual direction
- upd_target  input  32  actual target
- upd_pred_taken  input  1  prediction that was made for upd_pc at fetch
- upd_pred_target  input  32  predicted target that was made at fetch
- mispredict  output  1  registered pulse, one cycle after an update that mispredicted
- stat_branches  output  32  count of resolved updates
- stat_mispred  output  32  count of mispredicted updates

Behaviour:
- Index: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Same split applies to upd_pc.
- Lookup (combinational):
  - hit = valid[idx] && tag_mem[idx]==tag.
  - pred_taken = hit && ctr[idx][1] && !reset.
  - pred_target = hit ? target_mem[idx] : pc+4.
- Update (posedge clk, upd_valid=1, reset=0):
  - Hit, taken: ctr increments, saturating at 2'b11; target_mem overwritten with upd_target.
  - Hit, not taken: ctr decrements, saturating at 2'b00; target unchanged; entry stays valid.
  - Miss, taken: allocate. Write valid=1, tag, target=upd_target, ctr=CTR_ALLOC, replacing any existing entry (alias eviction).
  - Miss, not taken: no table write.
- Mispredict: mis = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target).
  - mispredict is registered: it equals mis one cycle after the upd_valid cycle, and is 0 when upd_valid=0.
  - stat_branches increments on every update; stat_mispred increments when mis=1. Both wrap modulo 2^32.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents, with no bypass. The new contents are visible from the next cycle.
- Updates are accepted every cycle, with no backpressure and no stall port. Prediction output does not depend on any stall signal.
- Reset: all valid bits cleared in one cycle.
  - ctr, tag and target arrays are not required to reset; valid gates them.
  - mispredict=0, stat_branches=0, stat_mispred=0.
  - pred_taken=0 while reset is high; pred_target=pc+4 after reset because every entry is invalid.
  - An update presented in a reset cycle is ignored, with no write and no count.
- pc+4 wraps modulo 2^32 (0xfffffffc -> 0x00000000).

Decomposition:
- Shared package: IDX_W default, the CTR_ALLOC constant, and an entry struct {valid, tag, target, ctr}.
- One natural sub-module: sat_ctr2, the 2-bit saturating up/down next-state function (combinational). Instantiate it once on the update path.
- Table storage is flops (valid needs a one-cycle clear), kept in the top level.

Test Plan:
- Reset, then pc=0x00000100 -> pred_taken=0, pred_target=0x00000104; stats=0; mispredict=0.
- Update pc=0x100, taken, target=0x200, pred_taken=0 -> next cycle mispredict=1, stat_mispred=1. Lookup 0x100 -> pred_taken=1, pred_target=0x200 (ctr=10).
- Two further not-taken updates of 0x100 -> ctr goes 10, 01, 00. Lookup gives pred_taken=0, pred_target=0x200. Third not-taken update holds at 00. Two taken updates -> pred_taken=1.
- Alias: entry for 0x100 valid, lookup 0x100+(1<<(IDX_W+2)) -> miss, pred_target=pc+4. Taken update of the alias evicts the entry, so 0x100 then misses.
- Same-cycle lookup and allocating update on 0x300 -> that cycle pred_taken=0; next cycle pred_taken=1. Correctly predicted update (taken, targets equal) -> mispredict=0, stat_branches increments only.
- Reset asserted mid-run with valid entries and upd_valid=1 -> no write, all lookups miss afterwards, counters=0. Preload stat_branches near 0xffffffff via updates or force -> verify wrap to 0.
